// File: rtl/controller_sequencer.sv
// Six-phase (T1..T6) ring-counter sequencer for the 8-bit bus computer.
// Fetch strobes come from T alone; execute strobes come from T and the IR opcode.
module controller_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       en,
  input  logic [3:0] ir_op,
  output logic       enPC,
  output logic       OE_PC,
  output logic       load_MAR,
  output logic       OE_RAM,
  output logic       WE_IR,
  output logic       OE_IR,
  output logic       WE_Acc,
  output logic       OE_Acc,
  output logic       WE_Breg,
  output logic       OE_ALU,
  output logic       SUB,
  output logic       WE_OR,
  output logic       HLT,
  output logic [2:0] tstate,
  output logic       instr_done
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Handshake: en=1 advances one T-state per clock; en=0 holds T and forces every
  // strobe low. Once halted, T is frozen at T4 until RESET.
  logic [5:0] t_q;
  logic       halted_q;
  logic       active;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      t_q      <= 6'b000001;
      halted_q <= 1'b0;
    end else if (en && !halted_q) begin
      if (t_q[3] && ir_op == OP_HLT) halted_q <= 1'b1;
      else                           t_q      <= {t_q[4:0], t_q[5]};
    end
  end

  assign active = en && !halted_q && !RESET;

  always_comb begin
    tstate = 3'd1;
    if (!RESET) begin
      unique case (1'b1)
        t_q[1]:  tstate = 3'd2;
        t_q[2]:  tstate = 3'd3;
        t_q[3]:  tstate = 3'd4;
        t_q[4]:  tstate = 3'd5;
        t_q[5]:  tstate = 3'd6;
        default: tstate = 3'd1;
      endcase
    end
  end

  always_comb begin
    enPC     = 1'b0;
    OE_PC    = 1'b0;
    load_MAR = 1'b0;
    OE_RAM   = 1'b0;
    WE_IR    = 1'b0;
    OE_IR    = 1'b0;
    WE_Acc   = 1'b0;
    OE_Acc   = 1'b0;
    WE_Breg  = 1'b0;
    OE_ALU   = 1'b0;
    SUB      = 1'b0;
    WE_OR    = 1'b0;
    if (active) begin
      if (t_q[0]) begin
        OE_PC    = 1'b1;
        load_MAR = 1'b1;
      end
      if (t_q[1]) enPC = 1'b1;
      if (t_q[2]) begin
        OE_RAM = 1'b1;
        WE_IR  = 1'b1;
      end
      // Execute phases: the opcode is only looked at from T4 onward.
      case (ir_op)
        OP_LDA: begin
          if (t_q[3]) begin OE_IR = 1'b1; load_MAR = 1'b1; end
          if (t_q[4]) begin OE_RAM = 1'b1; WE_Acc = 1'b1; end
        end
        OP_ADD, OP_SUB: begin
          if (t_q[3]) begin OE_IR = 1'b1; load_MAR = 1'b1; end
          if (t_q[4]) begin OE_RAM = 1'b1; WE_Breg = 1'b1; end
          if (t_q[5]) begin OE_ALU = 1'b1; WE_Acc = 1'b1; end
          // SUB is raised a phase early so the ALU result has settled by the Acc load.
          if (ir_op == OP_SUB && (t_q[4] || t_q[5])) SUB = 1'b1;
        end
        OP_OUT: begin
          if (t_q[3]) begin OE_Acc = 1'b1; WE_OR = 1'b1; end
        end
        default: ;
      endcase
    end
  end

  assign HLT        = !RESET && (halted_q || (active && t_q[3] && ir_op == OP_HLT));
  assign instr_done = active && t_q[5];

endmodule

// File: tb/tb_controller_sequencer.sv
// Vector bench for controller_sequencer: each record is one clock of inputs plus the
// outputs expected during that clock, queued on drive and checked mid-cycle.
module tb_controller_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, en;
  logic [3:0] ir_op;
  logic       enPC, OE_PC, load_MAR, OE_RAM, WE_IR, OE_IR, WE_Acc, OE_Acc;
  logic       WE_Breg, OE_ALU, SUB, WE_OR, HLT, instr_done;
  logic [2:0] tstate;

  always #5 CLK = ~CLK;

  controller_sequencer dut (
    .CLK(CLK), .RESET(RESET), .en(en), .ir_op(ir_op),
    .enPC(enPC), .OE_PC(OE_PC), .load_MAR(load_MAR), .OE_RAM(OE_RAM),
    .WE_IR(WE_IR), .OE_IR(OE_IR), .WE_Acc(WE_Acc), .OE_Acc(OE_Acc),
    .WE_Breg(WE_Breg), .OE_ALU(OE_ALU), .SUB(SUB), .WE_OR(WE_OR),
    .HLT(HLT), .tstate(tstate), .instr_done(instr_done)
  );

  // Strobe bit positions within the 14-bit strobe field.
  localparam logic [13:0] S_ENPC = 14'h2000, S_OEPC = 14'h1000, S_LMAR = 14'h0800;
  localparam logic [13:0] S_OERAM = 14'h0400, S_WEIR = 14'h0200, S_OEIR = 14'h0100;
  localparam logic [13:0] S_WEACC = 14'h0080, S_OEACC = 14'h0040, S_WEB = 14'h0020;
  localparam logic [13:0] S_OEALU = 14'h0010, S_SUB = 14'h0008, S_WEOR = 14'h0004;
  localparam logic [13:0] S_HLT = 14'h0002, S_DONE = 14'h0001, S_NONE = 14'h0000;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  op;
    logic [16:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];
  logic [16:0] obs;
  int          tests_run = 0;
  int          tests_failed = 0;

  assign obs = {tstate, enPC, OE_PC, load_MAR, OE_RAM, WE_IR, OE_IR, WE_Acc, OE_Acc,
                WE_Breg, OE_ALU, SUB, WE_OR, HLT, instr_done};

  task automatic add(input logic rst, input logic e, input logic [3:0] op,
                     input logic [2:0] t, input logic [13:0] s);
    vec_t v;
    v.rst = rst; v.en = e; v.op = op; v.exp = {t, s};
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [3:0] op);
    add(1'b0, 1'b1, op, 3'd1, S_OEPC | S_LMAR);
    add(1'b0, 1'b1, op, 3'd2, S_ENPC);
    add(1'b0, 1'b1, op, 3'd3, S_OERAM | S_WEIR);
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [16:0] want;
    RESET = v.rst;
    en    = v.en;
    ir_op = v.op;
    exp_q.push_back(v.exp);
    #4;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL vec%0d scoreboard empty", idx);
    end else begin
      want = exp_q.pop_front();
      if (obs !== want) begin
        tests_failed++;
        $display("FAIL vec%0d rst=%0b en=%0b op=%04b: got t=%0d s=%014b, want t=%0d s=%014b",
                 idx, v.rst, v.en, v.op, obs[16:14], obs[13:0], want[16:14], want[13:0]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vecs(input int base);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], base + i);
    vecs.delete();
  endtask

  initial begin
    RESET = 1'b1;
    en    = 1'b0;
    ir_op = 4'h0;
    @(posedge CLK);
    #1;

    // Straight-line instruction stream: reset, then LDA, SUB, ADD, OUT, NOP.
    add(1'b1, 1'b1, 4'h0, 3'd1, S_NONE);
    add_fetch(4'h0);
    add(1'b0, 1'b1, 4'h0, 3'd4, S_OEIR | S_LMAR);
    add(1'b0, 1'b1, 4'h0, 3'd5, S_OERAM | S_WEACC);
    add(1'b0, 1'b1, 4'h0, 3'd6, S_DONE);
    add_fetch(4'h2);
    add(1'b0, 1'b1, 4'h2, 3'd4, S_OEIR | S_LMAR);
    add(1'b0, 1'b1, 4'h2, 3'd5, S_OERAM | S_WEB | S_SUB);
    add(1'b0, 1'b1, 4'h2, 3'd6, S_OEALU | S_WEACC | S_SUB | S_DONE);
    add_fetch(4'h1);
    add(1'b0, 1'b1, 4'h1, 3'd4, S_OEIR | S_LMAR);
    add(1'b0, 1'b1, 4'h1, 3'd5, S_OERAM | S_WEB);
    add(1'b0, 1'b1, 4'h1, 3'd6, S_OEALU | S_WEACC | S_DONE);
    add_fetch(4'hE);
    add(1'b0, 1'b1, 4'hE, 3'd4, S_OEACC | S_WEOR);
    add(1'b0, 1'b1, 4'hE, 3'd5, S_NONE);
    add(1'b0, 1'b1, 4'hE, 3'd6, S_DONE);
    add_fetch(4'h5);
    add(1'b0, 1'b1, 4'h5, 3'd4, S_NONE);
    add(1'b0, 1'b1, 4'h5, 3'd5, S_NONE);
    add(1'b0, 1'b1, 4'h5, 3'd6, S_DONE);
    run_vecs(0);

    // Halt: HLT in T4, then frozen for 20+ clocks regardless of en or ir_op, until RESET.
    add_fetch(4'hF);
    add(1'b0, 1'b1, 4'hF, 3'd4, S_HLT);
    for (int i = 0; i < 20; i++) add(1'b0, 1'b1, 4'hF, 3'd4, S_HLT);
    add(1'b0, 1'b0, 4'hF, 3'd4, S_HLT);
    add(1'b0, 1'b1, 4'h0, 3'd4, S_HLT);
    add(1'b1, 1'b1, 4'h0, 3'd1, S_NONE);
    run_vecs(100);

    // Pause in T1, T5 and T6 of an ADD; then RESET in T5 abandons the next ADD.
    add(1'b0, 1'b0, 4'h1, 3'd1, S_NONE);
    add_fetch(4'h1);
    add(1'b0, 1'b1, 4'h1, 3'd4, S_OEIR | S_LMAR);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 4'h1, 3'd5, S_NONE);
    add(1'b0, 1'b1, 4'h1, 3'd5, S_OERAM | S_WEB);
    add(1'b0, 1'b0, 4'h1, 3'd6, S_NONE);
    add(1'b0, 1'b1, 4'h1, 3'd6, S_OEALU | S_WEACC | S_DONE);
    add_fetch(4'h1);
    add(1'b0, 1'b1, 4'h1, 3'd4, S_OEIR | S_LMAR);
    add(1'b1, 1'b1, 4'h1, 3'd1, S_NONE);
    add(1'b0, 1'b1, 4'h1, 3'd1, S_OEPC | S_LMAR);
    add(1'b0, 1'b1, 4'h1, 3'd2, S_ENPC);
    run_vecs(200);

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
